// File: rtl/param_updown_counter_pkg.sv
// rtl/param_updown_counter_pkg.sv - shared constants, clamp helper and parameter legality check
package counter_pkg;

   localparam int CNT_MODE_WRAP = 0;
   localparam int CNT_MODE_SAT  = 1;

   // Wide enough for any legal DATA_WIDTH plus one carry bit.
   localparam int CNT_CALC_W = 33;

   function automatic logic [CNT_CALC_W-1:0] min_u(
      input logic [CNT_CALC_W-1:0] a,
      input logic [CNT_CALC_W-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

   function automatic bit cnt_params_legal(
      input int              dw,
      input int              sw,
      input int              sat,
      input longint unsigned maxv,
      input longint unsigned rstv
   );
      longint unsigned lim;
      lim = (64'd1 << dw) - 64'd1;
      return (dw >= 2) && (dw <= 32) &&
             (sw >= 1) && (sw <= dw) &&
             ((sat == CNT_MODE_WRAP) || (sat == CNT_MODE_SAT)) &&
             (maxv >= 64'd1) && (maxv <= lim) &&
             (rstv <= maxv);
   endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// rtl/param_updown_counter_if.sv - command and status bundle for one counter instance
interface param_updown_counter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int STEP_WIDTH = 4
);
   logic                  en;
   logic                  load;
   logic [DATA_WIDTH-1:0] d;
   logic                  up_down;
   logic [STEP_WIDTH-1:0] step;
   logic                  ovf_clr;

   logic [DATA_WIDTH-1:0] qd;
   logic                  tc;
   logic                  ovf;
   logic                  at_max;
   logic                  at_zero;

   modport master (
      output en, load, d, up_down, step, ovf_clr,
      input  qd, tc, ovf, at_max, at_zero
   );

   modport slave (
      input  en, load, d, up_down, step, ovf_clr,
      output qd, tc, ovf, at_max, at_zero
   );
endinterface

// File: rtl/param_updown_counter_next.sv
// rtl/param_updown_counter_next.sv - next-value arithmetic with wrap or saturate at the range bounds
module param_counter_next
   import counter_pkg::*;
#(
   parameter int              DATA_WIDTH = 8,
   parameter longint unsigned MAX_VALUE  = (64'd1 << DATA_WIDTH) - 64'd1,
   parameter int              SATURATE   = CNT_MODE_WRAP
)(
   input  logic [DATA_WIDTH-1:0] i_qd,
   input  logic [DATA_WIDTH-1:0] i_step,
   input  logic                  i_up_down,
   output logic [DATA_WIDTH-1:0] o_next,
   output logic                  o_cross
);

   // One extra bit so qd+step and qd+modulus never overflow.
   localparam logic [DATA_WIDTH:0] LP_MAX = (DATA_WIDTH+1)'(MAX_VALUE);
   localparam logic [DATA_WIDTH:0] LP_MOD = (DATA_WIDTH+1)'(MAX_VALUE + 64'd1);
   localparam bit                  LP_SAT = (SATURATE == CNT_MODE_SAT);

   logic [DATA_WIDTH:0] w_qd_ext;
   logic [DATA_WIDTH:0] w_s_ext;
   logic [DATA_WIDTH:0] w_sum;

   always_comb begin
      w_qd_ext = {1'b0, i_qd};
      w_s_ext  = {1'b0, i_step};
      w_sum    = w_qd_ext + w_s_ext;
      o_next   = i_qd;
      o_cross  = 1'b0;
      if (i_up_down) begin
         if (w_sum <= LP_MAX) begin
            o_next = DATA_WIDTH'(w_sum);
         end else begin
            o_cross = 1'b1;
            o_next  = LP_SAT ? DATA_WIDTH'(LP_MAX) : DATA_WIDTH'(w_sum - LP_MOD);
         end
      end else begin
         if (w_s_ext <= w_qd_ext) begin
            o_next = i_qd - i_step;
         end else begin
            o_cross = 1'b1;
            o_next  = LP_SAT ? '0 : DATA_WIDTH'(w_qd_ext + LP_MOD - w_s_ext);
         end
      end
   end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - loadable up/down counter with bound, step, wrap/saturate and sticky overflow
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int              DATA_WIDTH  = 8,
   parameter int              STEP_WIDTH  = 4,
   parameter longint unsigned MAX_VALUE   = (64'd1 << DATA_WIDTH) - 64'd1,
   parameter int              SATURATE    = CNT_MODE_WRAP,
   parameter longint unsigned RESET_VALUE = 64'd0
)(
   input  logic                 clk,
   input  logic                 clear,
   param_updown_counter_if.slave bus
);

   localparam bit LP_LEGAL = cnt_params_legal(DATA_WIDTH, STEP_WIDTH, SATURATE,
                                              MAX_VALUE, RESET_VALUE);

   generate
      if (!LP_LEGAL) begin : g_param_error
         $error("param_updown_counter: illegal parameter combination");
      end
   endgenerate

   localparam logic [DATA_WIDTH:0]   LP_MAX = (DATA_WIDTH+1)'(MAX_VALUE);
   localparam logic [DATA_WIDTH-1:0] LP_RST = DATA_WIDTH'(RESET_VALUE);

   logic [DATA_WIDTH-1:0] r_qd;
   logic                  r_tc;
   logic                  r_ovf;

   logic [DATA_WIDTH-1:0] w_d_clamp;
   logic [DATA_WIDTH-1:0] w_step;
   logic [DATA_WIDTH-1:0] w_next;
   logic                  w_cross;
   logic [DATA_WIDTH-1:0] w_qd_nxt;
   logic                  w_tc_nxt;

   // A step larger than the whole range is treated as a full-range step.
   assign w_d_clamp = DATA_WIDTH'(min_u(CNT_CALC_W'(bus.d),    CNT_CALC_W'(LP_MAX)));
   assign w_step    = DATA_WIDTH'(min_u(CNT_CALC_W'(bus.step), CNT_CALC_W'(LP_MAX)));

   param_counter_next #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_VALUE  (MAX_VALUE),
      .SATURATE   (SATURATE)
   ) u_next (
      .i_qd      (r_qd),
      .i_step    (w_step),
      .i_up_down (bus.up_down),
      .o_next    (w_next),
      .o_cross   (w_cross)
   );

   always_comb begin
      w_qd_nxt = r_qd;
      w_tc_nxt = 1'b0;
      if (bus.load) begin
         w_qd_nxt = w_d_clamp;
      end else if (bus.en) begin
         w_qd_nxt = w_next;
         w_tc_nxt = w_cross;
      end
   end

   // A terminal event on the same edge as ovf_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_qd  <= LP_RST;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         r_qd <= w_qd_nxt;
         r_tc <= w_tc_nxt;
         if (w_tc_nxt) begin
            r_ovf <= 1'b1;
         end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign bus.qd      = r_qd;
   assign bus.tc      = r_tc;
   assign bus.ovf     = r_ovf;
   assign bus.at_max  = ({1'b0, r_qd} == LP_MAX);
   assign bus.at_zero = (r_qd == '0);

endmodule
